// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
// Execution datapath of the 16-bit fetch/decode/execute CPU: a 16-entry
// register file with ALU, the program counter and a data RAM. All three share
// one combinational internal bus.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   opcode               [15:12] class, [11:8] sub/cond, [7:4] rd, [3:0] rs/rsel
//   operand              immediate / RAM address / jump target
//   data_in              external bus source (lowest bus priority)
//   alu_read_en          R[rsel] onto bus
//   alu_write_en         register file write (ALU op or bus load)
//   ram_read_en          mem[addr] onto bus
//   ram_write_en         mem[addr] <= bus
//   pc_read_en           pc onto bus
//   pc_en                pc update (jump or increment)
//   data_out             current bus value
//   flags                {V,N,C,Z}
//   pc_out               current pc
//
// Build option
//   RAM_CLEAR_ON_RESET_EN  when defined, reset also zeroes every RAM word.
// ---------------------------------------------------------------------------
module cpu_datapath #(
   parameter int DATA_WIDTH     = 16,
   parameter int RAM_ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] opcode,
   input  logic [DATA_WIDTH-1:0] operand,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  alu_read_en,
   input  logic                  alu_write_en,
   input  logic                  ram_read_en,
   input  logic                  ram_write_en,
   input  logic                  pc_read_en,
   input  logic                  pc_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [3:0]            flags,
   output logic [DATA_WIDTH-1:0] pc_out
);

   localparam int DW        = DATA_WIDTH;
   localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

   localparam logic [3:0] CLS_ALU     = 4'h1;
   localparam logic [3:0] CLS_JMP_BUS = 4'h7;
   localparam logic [3:0] CLS_JMP_IMM = 4'hF;

   logic [DW-1:0] r_regs [16];
   logic [DW-1:0] r_mem  [RAM_DEPTH];
   logic [DW-1:0] r_pc;
   logic [3:0]    r_flags;

   logic [3:0]                w_class, w_sub, w_rd, w_rs;
   logic [RAM_ADDR_WIDTH-1:0] w_addr;
   logic [DW-1:0]             w_bus;
   logic [DW-1:0]             w_a, w_b, w_res;
   logic [DW:0]               w_sum, w_diff, w_addi;
   logic                      w_c, w_v, w_wr, w_upd, w_cond;
   logic [3:0]                w_flags_nxt;

   assign w_class = opcode[15:12];
   assign w_sub   = opcode[11:8];
   assign w_rd    = opcode[7:4];
   assign w_rs    = opcode[3:0];
   assign w_addr  = operand[RAM_ADDR_WIDTH-1:0];

   always_comb begin
      if (alu_read_en)      w_bus = r_regs[w_rs];
      else if (ram_read_en) w_bus = r_mem[w_addr];
      else if (pc_read_en)  w_bus = r_pc;
      else                  w_bus = data_in;
   end

   assign data_out = w_bus;
   assign flags    = r_flags;
   assign pc_out   = r_pc;

   assign w_a    = r_regs[w_rd];
   assign w_b    = r_regs[w_rs];
   assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
   assign w_diff = {1'b0, w_a} - {1'b0, w_b};
   assign w_addi = {1'b0, w_a} + {1'b0, operand};

   // w_wr: destination register written; w_upd: flags register written.
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_wr  = 1'b1;
      w_upd = 1'b1;
      case (w_sub)
         4'h0: begin
            w_res = w_sum[DW-1:0];
            w_c   = w_sum[DW];
            w_v   = (w_a[DW-1] == w_b[DW-1]) && (w_res[DW-1] != w_a[DW-1]);
         end
         4'h1, 4'h9: begin
            w_res = w_diff[DW-1:0];
            w_c   = w_diff[DW];
            w_v   = (w_a[DW-1] != w_b[DW-1]) && (w_res[DW-1] != w_a[DW-1]);
            w_wr  = (w_sub == 4'h1);
         end
         4'h2: w_res = w_a & w_b;
         4'h3: w_res = w_a | w_b;
         4'h4: w_res = w_a ^ w_b;
         4'h5: w_res = ~w_b;
         4'h6: begin
            w_res = {w_a[DW-2:0], 1'b0};
            w_c   = w_a[DW-1];
         end
         4'h7: begin
            w_res = {1'b0, w_a[DW-1:1]};
            w_c   = w_a[0];
         end
         4'h8: begin
            w_res = w_addi[DW-1:0];
            w_c   = w_addi[DW];
            w_v   = (w_a[DW-1] == operand[DW-1]) && (w_res[DW-1] != w_a[DW-1]);
         end
         4'hA: w_res = w_b;
         4'hB: w_res = operand;
         default: begin
            w_wr  = 1'b0;
            w_upd = 1'b0;
         end
      endcase
   end

   assign w_flags_nxt = {w_v, w_res[DW-1], w_c, (w_res == '0)};

   // Jump condition is evaluated against the flags as they stand before this edge.
   always_comb begin
      case (w_sub)
         4'h0:    w_cond = 1'b1;
         4'h1:    w_cond = r_flags[0];
         4'h2:    w_cond = ~r_flags[0];
         4'h3:    w_cond = r_flags[1];
         4'h4:    w_cond = r_flags[2];
         default: w_cond = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= '0;
         r_flags <= '0;
         for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      end else begin
         if (pc_en) begin
            if (w_class == CLS_JMP_BUS && w_cond)      r_pc <= w_bus;
            else if (w_class == CLS_JMP_IMM && w_cond) r_pc <= operand;
            else                                       r_pc <= r_pc + 1'b1;
         end
         if (alu_write_en) begin
            if (w_class == CLS_ALU) begin
               if (w_wr)  r_regs[w_rd] <= w_res;
               if (w_upd) r_flags      <= w_flags_nxt;
            end else begin
               r_regs[w_rs] <= w_bus;
            end
         end
      end
   end

`ifdef RAM_CLEAR_ON_RESET_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAM_DEPTH; i++) r_mem[i] <= '0;
      end else if (ram_write_en) begin
         r_mem[w_addr] <= w_bus;
      end
   end
`else
   // No reset on the array; reset only blocks a write coinciding with it.
   always_ff @(posedge clk) begin
      if (ram_write_en && !reset) r_mem[w_addr] <= w_bus;
   end
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] opcode, operand, data_in;
   logic        alu_read_en, alu_write_en, ram_read_en, ram_write_en, pc_read_en, pc_en;
   logic [15:0] data_out, pc_out;
   logic [3:0]  flags;

   cpu_datapath dut (
      .clk(clk), .reset(reset), .opcode(opcode), .operand(operand), .data_in(data_in),
      .alu_read_en(alu_read_en), .alu_write_en(alu_write_en),
      .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
      .pc_read_en(pc_read_en), .pc_en(pc_en),
      .data_out(data_out), .flags(flags), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] AR = 6'b100000, AW = 6'b010000, RR = 6'b001000,
                          RW = 6'b000100, PR = 6'b000010, PE = 6'b000001;

   int n_vec = 0, n_err = 0;
   bit run = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_regs [16];
   logic [15:0] m_mem  [256];
   bit          m_ok   [256];
   logic [15:0] m_pc;
   logic [3:0]  m_flags;

   logic [15:0] t_bus, t_a, t_b, t_res, t_pc;
   int          t_full, t_s;
   bit          t_c, t_v, t_wr, t_upd, t_cond;

   function automatic int sx(input logic [15:0] x);
      return x[15] ? int'(x) - 65536 : int'(x);
   endfunction

   function automatic logic [15:0] m_bus();
      if (alu_read_en) return m_regs[opcode[3:0]];
      if (ram_read_en) return m_mem[operand[7:0]];
      if (pc_read_en)  return m_pc;
      return data_in;
   endfunction

   function automatic bit m_bus_ok();
      if (alu_read_en) return 1'b1;
      if (ram_read_en) return m_ok[operand[7:0]];
      return 1'b1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc = 0;
         m_flags = 0;
         for (int i = 0; i < 16; i++) m_regs[i] = 0;
`ifdef RAM_CLEAR_ON_RESET_EN
         for (int i = 0; i < 256; i++) begin m_mem[i] = 0; m_ok[i] = 1; end
`endif
      end else begin
         t_bus = m_bus();
         t_a = m_regs[opcode[7:4]];
         t_b = m_regs[opcode[3:0]];
         t_c = 0; t_v = 0; t_wr = 1; t_upd = 1; t_res = 0;
         case (opcode[11:8])
            4'h0: begin t_full = int'(t_a) + int'(t_b); t_s = sx(t_a) + sx(t_b);
                        t_res = 16'(t_full & 32'hFFFF); t_c = t_full > 65535;
                        t_v = (t_s > 32767) || (t_s < -32768); end
            4'h1, 4'h9: begin t_full = int'(t_a) - int'(t_b); t_s = sx(t_a) - sx(t_b);
                        t_res = 16'(t_full & 32'hFFFF); t_c = t_full < 0;
                        t_v = (t_s > 32767) || (t_s < -32768); t_wr = (opcode[11:8] == 4'h1); end
            4'h2: t_res = t_a & t_b;
            4'h3: t_res = t_a | t_b;
            4'h4: t_res = t_a ^ t_b;
            4'h5: t_res = ~t_b;
            4'h6: begin t_res = 16'((int'(t_a) * 2) & 32'hFFFF); t_c = t_a >= 16'h8000; end
            4'h7: begin t_res = t_a / 2; t_c = (t_a % 2) != 0; end
            4'h8: begin t_full = int'(t_a) + int'(operand); t_s = sx(t_a) + sx(operand);
                        t_res = 16'(t_full & 32'hFFFF); t_c = t_full > 65535;
                        t_v = (t_s > 32767) || (t_s < -32768); end
            4'hA: t_res = t_b;
            4'hB: t_res = operand;
            default: begin t_wr = 0; t_upd = 0; end
         endcase
         case (opcode[11:8])
            4'h0: t_cond = 1;
            4'h1: t_cond = m_flags[0];
            4'h2: t_cond = !m_flags[0];
            4'h3: t_cond = m_flags[1];
            4'h4: t_cond = m_flags[2];
            default: t_cond = 0;
         endcase
         if (opcode[15:12] == 4'h7 && t_cond)      t_pc = t_bus;
         else if (opcode[15:12] == 4'hF && t_cond) t_pc = operand;
         else                                      t_pc = 16'((int'(m_pc) + 1) % 65536);
         if (pc_en) m_pc = t_pc;
         if (alu_write_en) begin
            if (opcode[15:12] == 4'h1) begin
               if (t_wr)  m_regs[opcode[7:4]] = t_res;
               if (t_upd) m_flags = {t_v, t_res >= 16'h8000, t_c, t_res == 16'h0};
            end else begin
               m_regs[opcode[3:0]] = t_bus;
            end
         end
         if (ram_write_en) begin
            m_mem[operand[7:0]] = t_bus;
            m_ok[operand[7:0]] = 1;
         end
      end
   end

   // compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (run && !reset) begin
         if (m_bus_ok()) check("bus", data_out, m_bus());
         check("flags", {12'h0, flags}, {12'h0, m_flags});
         check("pc", pc_out, m_pc);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [15:0] op, input logic [15:0] opnd,
                        input logic [15:0] din, input logic [5:0] en);
      opcode = op; operand = opnd; data_in = din;
      {alu_read_en, alu_write_en, ram_read_en, ram_write_en, pc_read_en, pc_en} = en;
   endtask

   task automatic tick();
      @(posedge clk); @(negedge clk); #1;
   endtask

   task automatic lit(input string name, input logic [15:0] exp);
      #1 check(name, data_out, exp);
   endtask

   typedef struct packed {
      logic [15:0] op;
      logic [15:0] opnd;
      logic [15:0] din;
      logic [5:0]  en;
   } vec_t;

   vec_t tbl [20] = '{
      '{16'h1256, 16'h0000, 16'h0000, AW},
      '{16'h1357, 16'h0000, 16'h0000, AW},
      '{16'h1467, 16'h0000, 16'h0000, AW},
      '{16'h1597, 16'h0000, 16'h0000, AW},
      '{16'h1670, 16'h0000, 16'h0000, AW},
      '{16'h1750, 16'h0000, 16'h0000, AW},
      '{16'h1860, 16'h7FFF, 16'h0000, AW},
      '{16'h1AA5, 16'h0000, 16'h0000, AW},
      '{16'h1C56, 16'h0000, 16'h0000, AW},
      '{16'h1F00, 16'h0000, 16'h0000, AW},
      '{16'h1077, 16'h0000, 16'h0000, AW},
      '{16'h0B00, 16'h0000, 16'hCAFE, AW},
      '{16'hF300, 16'h0200, 16'h0000, PE},
      '{16'hF400, 16'h0300, 16'h0000, PE},
      '{16'hF500, 16'h0400, 16'h0000, PE},
      '{16'h7000, 16'h0000, 16'h0555, PE},
      '{16'h7200, 16'h0000, 16'h0666, PE},
      '{16'h0005, 16'h0020, 16'h0000, AR | RW | PE},
      '{16'h0000, 16'h0020, 16'h0000, RR | AW},
      '{16'h0000, 16'h0000, 16'h0000, PR | AW | PE}
   };

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      drive(16'h0, 16'h0, 16'h0, 6'b0);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run = 1;
      #1;
      // reset state
      check("reset_pc", pc_out, 16'h0000);
      check("reset_flags", {12'h0, flags}, 16'h0000);
      drive(16'h0003, 16'h0, 16'h0, AR); lit("reset_r3", 16'h0000);

      // LDI / ADD wrap
      drive(16'h1B10, 16'hFFFF, 16'h0, AW); tick();
      drive(16'h1B20, 16'h0001, 16'h0, AW); tick();
      drive(16'h1012, 16'h0000, 16'h0, AW); tick();
      check("add_flags", {12'h0, flags}, 16'h0003);
      drive(16'h0001, 16'h0, 16'h0, AR); lit("add_r1", 16'h0000);
      drive(16'h0002, 16'h0, 16'h0, AR); lit("ldi_r2", 16'h0001);

      // RAM write/read, upper address bits ignored, register to RAM
      drive(16'h0000, 16'hAB05, 16'hBEEF, RW); tick();
      drive(16'h0000, 16'h0005, 16'h0000, RR); lit("ram5", 16'hBEEF);
      drive(16'h0004, 16'h0000, 16'h1234, AW); tick();
      drive(16'h9104, 16'h0010, 16'h0000, AR | RW); tick();
      drive(16'h0000, 16'h0010, 16'h0000, RR); lit("ram10_r4", 16'h1234);
      // bus priority
      drive(16'h0004, 16'h0005, 16'hDEAD, AR | RR | PR); lit("prio_alu", 16'h1234);
      drive(16'h0004, 16'h0005, 16'hDEAD, RR | PR);      lit("prio_ram", 16'hBEEF);
      drive(16'h0004, 16'h0005, 16'hDEAD, PR);           lit("prio_pc", 16'h0000);
      drive(16'h0004, 16'h0005, 16'hDEAD, 6'b0);         lit("prio_din", 16'hDEAD);
      // read+write same address same cycle: bus shows old data
      drive(16'h0000, 16'h0005, 16'h7777, RR | RW);      lit("rw_same", 16'hBEEF);
      tick();

      // PC
      repeat (3) begin drive(16'h0000, 16'h0, 16'h0, PE); tick(); end
      check("pc_inc3", pc_out, 16'h0003);
      drive(16'hF000, 16'h0040, 16'h0, PE); tick();
      check("pc_jmp", pc_out, 16'h0040);
      drive(16'h1B30, 16'h0005, 16'h0, AW); tick();
      drive(16'hF100, 16'h0080, 16'h0, PE); tick();
      check("pc_jz_not_taken", pc_out, 16'h0041);
      drive(16'hF000, 16'hFFFF, 16'h0, PE); tick();
      drive(16'h0000, 16'h0000, 16'h0, PE); tick();
      check("pc_wrap", pc_out, 16'h0000);
      drive(16'h0000, 16'h0007, 16'h0123, RW); tick();
      drive(16'h7000, 16'h0007, 16'h0000, RR | PE); tick();
      check("pc_jmp_bus", pc_out, 16'h0123);

      // SUB borrow and CMP overflow
      drive(16'h1B50, 16'h0000, 16'h0, AW); tick();
      drive(16'h1B60, 16'h0001, 16'h0, AW); tick();
      drive(16'h1156, 16'h0000, 16'h0, AW); tick();
      check("sub_flags", {12'h0, flags}, 16'h0006);
      drive(16'h0005, 16'h0, 16'h0, AR); lit("sub_r5", 16'hFFFF);
      drive(16'h1B70, 16'h8000, 16'h0, AW); tick();
      drive(16'h1B80, 16'h0001, 16'h0, AW); tick();
      drive(16'h1978, 16'h0000, 16'h0, AW); tick();
      check("cmp_flags", {12'h0, flags}, 16'h0008);
      drive(16'h0007, 16'h0, 16'h0, AR); lit("cmp_r7", 16'h8000);

      // broad op table, model-checked each cycle
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].op, tbl[i].opnd, tbl[i].din, tbl[i].en);
         tick();
      end
      for (int r = 0; r < 16; r++) begin
         drive(16'(r), 16'h0, 16'h0, AR);
         tick();
      end

      // reset mid-cycle with a pending register write
      drive(16'h0001, 16'h0000, 16'h5555, AW | PE);
      #1 reset = 1'b1;
      @(posedge clk); #2 reset = 1'b0;
      @(negedge clk); #1;
      drive(16'h0001, 16'h0, 16'h0, AR); lit("rst_r1", 16'h0000);
      check("rst_pc", pc_out, 16'h0000);
      drive(16'h0000, 16'h0005, 16'h0, RR);
`ifdef RAM_CLEAR_ON_RESET_EN
      lit("rst_ram5", 16'h0000);
`else
      lit("rst_ram5", 16'hBEEF);
`endif
      tick();

      run = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
